// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//
// Shares one single-port 32-bit data memory between two requesters
// (master 0: CPU load/store unit, master 1: DMA/peripheral engine).
// Round-robin arbitration, byte/half/word lane steering on writes,
// lane extraction plus sign/zero extension on reads.
//
// Each access takes three cycles: IDLE (arbitrate + register request),
// ACCESS (drive the memory, capture read data), RESP (ack pulse).
//
// Ports:
//   Clk, Reset          clock (rising edge), synchronous active-high reset
//   mX_req              request level, fields held stable until mX_ack
//   mX_we               1 = store, 0 = load
//   mX_size             00 byte, 01 half, 10 word, 11 reserved (error)
//   mX_signed           load extension: 1 = sign, 0 = zero
//   mX_addr             byte address
//   mX_wdata            right-aligned store data
//   mX_ack              one-cycle completion pulse
//   mX_err              error flag, valid with mX_ack
//   mX_rdata            load result, valid with mX_ack, held otherwise
//   dm_a                memory word address
//   dm_din              lane-replicated write data
//   dm_be               byte enables (zero outside a valid access)
//   dm_we               write enable
//   dm_dout             memory combinational read data
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int AW = 15
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [1:0]    m0_size,
  input  logic          m0_signed,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [1:0]    m1_size,
  input  logic          m1_signed,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [31:0]   m1_rdata,
  output logic [AW-3:0] dm_a,
  output logic [31:0]   dm_din,
  output logic [3:0]    dm_be,
  output logic          dm_we,
  input  logic [31:0]   dm_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q;
  logic          owner_q;       // 0 = master 0, 1 = master 1
  logic          last_grant_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;
  logic [31:0]   m0_rdata_q, m1_rdata_q;

  logic [1:0]    lane;
  logic          acc_err;
  logic [3:0]    acc_be;
  logic [31:0]   acc_din;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;
  logic [31:0]   capture_d;
  logic          pick_m1;

  assign lane = addr_q[1:0];

  // On a tie, the master that was not served last wins.
  assign pick_m1 = m1_req & (~m0_req | ~last_grant_q);

  // Lane steering and alignment check for the registered request.
  always_comb begin
    acc_err = 1'b0;
    acc_be  = 4'b0000;
    acc_din = wdata_q;
    case (size_q)
      2'b00: begin
        acc_be  = 4'b0001 << lane;
        acc_din = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        acc_be  = lane[1] ? 4'b1100 : 4'b0011;
        acc_din = {2{wdata_q[15:0]}};
        acc_err = lane[0];
      end
      2'b10: begin
        acc_be  = 4'b1111;
        acc_err = |lane;
      end
      default: acc_err = 1'b1;
    endcase
  end

  // Read-data extraction and extension.
  always_comb begin
    byte_sel = dm_dout[7:0];
    case (lane)
      2'd1:    byte_sel = dm_dout[15:8];
      2'd2:    byte_sel = dm_dout[23:16];
      2'd3:    byte_sel = dm_dout[31:24];
      default: byte_sel = dm_dout[7:0];
    endcase
    half_sel = lane[1] ? dm_dout[31:16] : dm_dout[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sgn_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{sgn_q & half_sel[15]}}, half_sel};
      default: load_val = dm_dout;
    endcase
    capture_d = (we_q | acc_err) ? 32'h0 : load_val;
  end

  assign dm_a   = addr_q[AW-1:2];
  assign dm_din = acc_din;
  assign dm_be  = (state_q == ACCESS && !acc_err) ? acc_be : 4'b0000;
  // Gated directly by Reset so a reset landing in ACCESS never writes.
  assign dm_we  = (state_q == ACCESS) & we_q & ~acc_err & ~Reset;

  assign m0_ack   = m0_ack_q;
  assign m0_err   = m0_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_ack   = m1_ack_q;
  assign m1_err   = m1_err_q;
  assign m1_rdata = m1_rdata_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= 32'h0;
      m1_rdata_q   <= 32'h0;
    end else begin
      // Acks are single-cycle pulses; set only on the ACCESS edge.
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req | m1_req) begin
            owner_q <= pick_m1;
            we_q    <= pick_m1 ? m1_we     : m0_we;
            size_q  <= pick_m1 ? m1_size   : m0_size;
            sgn_q   <= pick_m1 ? m1_signed : m0_signed;
            addr_q  <= pick_m1 ? m1_addr   : m0_addr;
            wdata_q <= pick_m1 ? m1_wdata  : m0_wdata;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (owner_q) begin
            m1_ack_q   <= 1'b1;
            m1_err_q   <= acc_err;
            m1_rdata_q <= capture_d;
          end else begin
            m0_ack_q   <= 1'b1;
            m0_err_q   <= acc_err;
            m0_rdata_q <= capture_d;
          end
          state_q <= RESP;
        end
        RESP: begin
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        m0_req, m0_we, m0_signed;
  logic [1:0]  m0_size;
  logic [14:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we, m1_signed;
  logic [1:0]  m1_size;
  logic [14:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic [12:0] dm_a;
  logic [31:0] dm_din;
  logic [3:0]  dm_be;
  logic        dm_we;
  logic [31:0] dm_dout;

  int errors = 0;
  int checks = 0;

  // observation variables filled by xfer
  logic        o_we, o_ack, o_err, o_early, o_xack;
  logic [3:0]  o_be;
  logic [12:0] o_a;
  logic [31:0] o_din, o_rdata;

  logic [31:0] mem [0:8191];

  dm_port_arbiter #(.AW(15)) dut (
    .Clk(Clk), .Reset(Reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_signed(m0_signed),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_signed(m1_signed),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .m1_rdata(m1_rdata),
    .dm_a(dm_a), .dm_din(dm_din), .dm_be(dm_be), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  always #5 Clk = ~Clk;

  // memory model: combinational read, byte-enabled synchronous write
  assign dm_dout = mem[dm_a];
  always @(posedge Clk) begin
    if (dm_we) begin
      if (dm_be[0]) mem[dm_a][7:0]   <= dm_din[7:0];
      if (dm_be[1]) mem[dm_a][15:8]  <= dm_din[15:8];
      if (dm_be[2]) mem[dm_a][23:16] <= dm_din[23:16];
      if (dm_be[3]) mem[dm_a][31:24] <= dm_din[31:24];
    end
  end

  task automatic drive(input bit m, input logic req, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [14:0] ad, input logic [31:0] wd);
    if (!m) begin
      m0_req = req; m0_we = we; m0_size = sz; m0_signed = sg; m0_addr = ad; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_size = sz; m1_signed = sg; m1_addr = ad; m1_wdata = wd;
    end
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Reset = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 15'h0, 32'h0);
    drive(1, 0, 0, 2'b00, 0, 15'h0, 32'h0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  // One complete transaction on master m with the DUT starting in IDLE.
  task automatic xfer(input bit m, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [14:0] ad, input logic [31:0] wd);
    @(posedge Clk); #1;
    drive(m, 1, we, sz, sg, ad, wd);
    @(posedge Clk); #1;          // ACCESS
    o_we = dm_we; o_be = dm_be; o_a = dm_a; o_din = dm_din;
    o_early = m ? m1_ack : m0_ack;
    @(posedge Clk); #1;          // RESP
    o_ack   = m ? m1_ack : m0_ack;
    o_err   = m ? m1_err : m0_err;
    o_rdata = m ? m1_rdata : m0_rdata;
    o_xack  = m ? m0_ack : m1_ack;
    drive(m, 0, we, sz, sg, ad, wd);
    $display("xfer m%0d we=%0b size=%0d addr=0x%04h wdata=0x%08h -> dm_we=%0b be=%04b a=0x%03h din=0x%08h ack=%0b err=%0b rdata=0x%08h",
             m, we, sz, ad, wd, o_we, o_be, o_a, o_din, o_ack, o_err, o_rdata);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_acks got=%04b exp=0000", {m0_ack, m1_ack, m0_err, m1_err});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata got m0=0x%08h m1=0x%08h exp 0", m0_rdata, m1_rdata);
    end
    checks++;
    if ({dm_we, dm_be, dm_a, dm_din} !== 50'h0) begin
      errors++; $display("FAIL reset_mem_if got we=%0b be=%04b a=0x%03h din=0x%08h exp 0", dm_we, dm_be, dm_a, dm_din);
    end
  endtask

  task automatic test_word();
    xfer(0, 1, 2'b10, 0, 15'h0010, 32'hDEADBEEF);
    checks++;
    if ({o_we, o_be, o_a, o_din} !== {1'b1, 4'b1111, 13'h004, 32'hDEADBEEF}) begin
      errors++; $display("FAIL word_store_if got we=%0b be=%04b a=0x%03h din=0x%08h exp 1/1111/004/deadbeef", o_we, o_be, o_a, o_din);
    end
    checks++;
    if ({o_early, o_ack, o_err} !== 3'b010) begin
      errors++; $display("FAIL word_store_ack got early=%0b ack=%0b err=%0b exp 0/1/0", o_early, o_ack, o_err);
    end
    xfer(0, 0, 2'b10, 0, 15'h0010, 32'h0);
    checks++;
    if ({o_we, o_ack, o_err, o_rdata} !== {3'b010, 32'hDEADBEEF}) begin
      errors++; $display("FAIL word_load got we=%0b ack=%0b err=%0b rdata=0x%08h exp 0/1/0/deadbeef", o_we, o_ack, o_err, o_rdata);
    end
  endtask

  task automatic test_byte_half();
    xfer(0, 1, 2'b00, 0, 15'h0003, 32'h000000A5);
    checks++;
    if ({o_we, o_be, o_din} !== {1'b1, 4'b1000, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL byte_store got we=%0b be=%04b din=0x%08h exp 1/1000/a5a5a5a5", o_we, o_be, o_din);
    end
    xfer(0, 0, 2'b00, 1, 15'h0003, 32'h0);
    checks++;
    if (o_rdata !== 32'hFFFFFFA5) begin
      errors++; $display("FAIL byte_load_signed got=0x%08h exp=0xffffffa5", o_rdata);
    end
    xfer(0, 0, 2'b00, 0, 15'h0003, 32'h0);
    checks++;
    if (o_rdata !== 32'h000000A5) begin
      errors++; $display("FAIL byte_load_unsigned got=0x%08h exp=0x000000a5", o_rdata);
    end
    xfer(0, 1, 2'b01, 0, 15'h0006, 32'h00008001);
    checks++;
    if ({o_we, o_be, o_a, o_din} !== {1'b1, 4'b1100, 13'h001, 32'h80018001}) begin
      errors++; $display("FAIL half_store got we=%0b be=%04b a=0x%03h din=0x%08h exp 1/1100/001/80018001", o_we, o_be, o_a, o_din);
    end
    xfer(0, 0, 2'b01, 0, 15'h0006, 32'h0);
    checks++;
    if (o_rdata !== 32'h00008001) begin
      errors++; $display("FAIL half_load_unsigned got=0x%08h exp=0x00008001", o_rdata);
    end
    xfer(0, 0, 2'b01, 1, 15'h0006, 32'h0);
    checks++;
    if (o_rdata !== 32'hFFFF8001) begin
      errors++; $display("FAIL half_load_signed got=0x%08h exp=0xffff8001", o_rdata);
    end
  endtask

  task automatic test_misalign();
    xfer(0, 1, 2'b01, 0, 15'h0001, 32'h00001234);
    checks++;
    if ({o_we, o_be, o_ack, o_err, o_rdata} !== {1'b0, 4'b0000, 2'b11, 32'h0}) begin
      errors++; $display("FAIL half_misalign got we=%0b be=%04b ack=%0b err=%0b rdata=0x%08h exp 0/0000/1/1/0", o_we, o_be, o_ack, o_err, o_rdata);
    end
    xfer(0, 0, 2'b10, 0, 15'h0000, 32'h0);
    checks++;
    if ({o_err, o_rdata} !== {1'b0, 32'hA5000000}) begin
      errors++; $display("FAIL word0_unchanged got err=%0b rdata=0x%08h exp 0/a5000000", o_err, o_rdata);
    end
    xfer(0, 0, 2'b10, 0, 15'h0002, 32'h0);
    checks++;
    if ({o_ack, o_err, o_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL word_misalign got ack=%0b err=%0b rdata=0x%08h exp 1/1/0", o_ack, o_err, o_rdata);
    end
    xfer(0, 0, 2'b10, 0, 15'h0010, 32'h0);  // leave a nonzero rdata behind
    xfer(0, 1, 2'b11, 0, 15'h0010, 32'h12345678);
    checks++;
    if ({o_we, o_be, o_ack, o_err, o_rdata} !== {1'b0, 4'b0000, 2'b11, 32'h0}) begin
      errors++; $display("FAIL size11 got we=%0b be=%04b ack=%0b err=%0b rdata=0x%08h exp 0/0000/1/1/0", o_we, o_be, o_ack, o_err, o_rdata);
    end
    xfer(0, 0, 2'b10, 0, 15'h0010, 32'h0);
    checks++;
    if (o_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL size11_mem_unchanged got=0x%08h exp=0xdeadbeef", o_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_acks;
    do_reset();
    drive(0, 1, 0, 2'b10, 0, 15'h0010, 32'h0);
    drive(1, 1, 0, 2'b10, 0, 15'h0000, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge Clk); #1;
      exp_acks = (k == 2 || k == 8) ? 2'b10 : (k == 5 || k == 11) ? 2'b01 : 2'b00;
      checks++;
      if ({m0_ack, m1_ack} !== exp_acks) begin
        errors++; $display("FAIL rr_cycle%0d got {m0,m1}_ack=%02b exp=%02b", k, {m0_ack, m1_ack}, exp_acks);
      end
    end
    $display("round robin: m0_rdata=0x%08h m1_rdata=0x%08h", m0_rdata, m1_rdata);
    checks++;
    if ({m0_rdata, m1_rdata} !== {32'hDEADBEEF, 32'hA5000000}) begin
      errors++; $display("FAIL rr_rdata got m0=0x%08h m1=0x%08h exp deadbeef/a5000000", m0_rdata, m1_rdata);
    end
    // m1 alone, req held: served every third cycle
    m0_req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge Clk); #1;
      exp_acks = (k == 2 || k == 5 || k == 8) ? 2'b01 : 2'b00;
      checks++;
      if ({m0_ack, m1_ack} !== exp_acks) begin
        errors++; $display("FAIL m1_alone_cycle%0d got {m0,m1}_ack=%02b exp=%02b", k, {m0_ack, m1_ack}, exp_acks);
      end
    end
    m1_req = 1'b0;
    $display("m1 alone: three back-to-back accesses observed");
  endtask

  task automatic test_reset_mid();
    // make m0 the last grant so an unreset tie would go to m1
    xfer(0, 0, 2'b10, 0, 15'h0010, 32'h0);
    @(posedge Clk); #1;
    drive(1, 1, 1, 2'b10, 0, 15'h0020, 32'h11223344);
    @(posedge Clk); #1;          // ACCESS of m1 store
    checks++;
    if (dm_we !== 1'b1) begin
      errors++; $display("FAIL mid_access_we got=%0b exp=1", dm_we);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (dm_we !== 1'b0) begin
      errors++; $display("FAIL mid_reset_we_gate got=%0b exp=0", dm_we);
    end
    @(posedge Clk); #1;
    checks++;
    if ({m0_ack, m1_ack, m0_err, m1_err, dm_we, dm_be} !== 9'h0) begin
      errors++; $display("FAIL mid_reset_ctrl got acks=%02b errs=%02b we=%0b be=%04b exp 0", {m0_ack, m1_ack}, {m0_err, m1_err}, dm_we, dm_be);
    end
    checks++;
    if ({m0_rdata, m1_rdata, dm_a, dm_din} !== 109'h0) begin
      errors++; $display("FAIL mid_reset_data got m0=0x%08h m1=0x%08h a=0x%03h din=0x%08h exp 0", m0_rdata, m1_rdata, dm_a, dm_din);
    end
    Reset = 1'b0;
    m1_req = 1'b0;
    checks++;
    if (mem[8] !== 32'h0) begin
      errors++; $display("FAIL mid_reset_no_write got mem[0x20]=0x%08h exp 0", mem[8]);
    end
    @(posedge Clk); #1;
    drive(0, 1, 0, 2'b10, 0, 15'h0010, 32'h0);
    drive(1, 1, 0, 2'b10, 0, 15'h0000, 32'h0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    checks++;
    if ({m0_ack, m1_ack, m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL post_reset_tie got {m0,m1}_ack=%02b m0_rdata=0x%08h exp 10/deadbeef", {m0_ack, m1_ack}, m0_rdata);
    end
    $display("post-reset tie: m0_ack=%0b m1_ack=%0b", m0_ack, m1_ack);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    Reset = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 15'h0, 32'h0);
    drive(1, 0, 0, 2'b00, 0, 15'h0, 32'h0);
    test_reset();
    test_word();
    test_byte_half();
    test_misalign();
    test_round_robin();
    test_reset_mid();
    @(posedge Clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
